// File: rtl/smu_cfg_loader.sv
// smu_cfg_loader: deserialises an LSB-first configuration frame into a shadow
// register and commits it atomically to the SMU comparison registers.
//
// Optional feature macro: SMU_CFG_PARITY_EN. When defined, the frame carries
// one extra even-parity bit at index CFG_W. A mismatch raises sticky cfg_err.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   cfg_valid/ready   beat handshake, accepted when both high
//   cfg_bit           serial payload bit
//   cfg_start         marks the beat as bit 0 of a new frame
//   Reg*              committed configuration fields
//   SmuEn             committed configuration valid
//   load_done         one-cycle pulse on commit
//   cfg_err           sticky frame error (tied 0 without parity)
module smu_cfg_loader #(
    parameter int N                 = 2,
    parameter int K                 = 4,
    parameter int SMU_SEGMENT_SIZE  = 64,
    parameter int SMU_NUM_SEGMENTS  =
        (K + SMU_SEGMENT_SIZE - 1) / SMU_SEGMENT_SIZE,
    parameter int BITS_NUM_SEGMENTS =
        (SMU_NUM_SEGMENTS == 1) ? 1 : $clog2(SMU_NUM_SEGMENTS),
    parameter int CFG_W             =
        1 + BITS_NUM_SEGMENTS + 2 * SMU_SEGMENT_SIZE + 2 + $clog2(N)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    input  logic                         cfg_bit,
    input  logic                         cfg_start,
    output logic                         cfg_ready,
    output logic                         RegSmuEn,
    output logic [BITS_NUM_SEGMENTS-1:0] RegInpSel,
    output logic [SMU_SEGMENT_SIZE-1:0]  RegMask,
    output logic [SMU_SEGMENT_SIZE-1:0]  RegCmp,
    output logic [1:0]                   RegCmpSelect,
    output logic [$clog2(N)-1:0]         RegFsmCmp,
    output logic                         SmuEn,
    output logic                         load_done,
    output logic                         cfg_err
);

    localparam int FSM_W = $clog2(N);
    localparam int SEG   = SMU_SEGMENT_SIZE;
    localparam int BNS   = BITS_NUM_SEGMENTS;

`ifdef SMU_CFG_PARITY_EN
    localparam int FL = CFG_W + 1;
`else
    localparam int FL = CFG_W;
`endif

    localparam int CW = $clog2(CFG_W + 2);

    // Field offsets inside the shadow register
    localparam int O_SEL  = 1;
    localparam int O_MASK = O_SEL + BNS;
    localparam int O_CMP  = O_MASK + SEG;
    localparam int O_CS   = O_CMP + SEG;
    localparam int O_FSM  = O_CS + 2;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        COMMIT,
        ACTIVE,
        ERR
    } state_t;

    state_t          state;
    logic [FL-1:0]   shadow;
    logic [CW-1:0]   cnt;
    logic            acc;
    logic            frame_ok;

    assign cfg_ready = (state != COMMIT);
    assign acc       = cfg_valid & cfg_ready;

`ifdef SMU_CFG_PARITY_EN
    // Even parity: payload plus parity bit must XOR to zero
    assign frame_ok = ~(^shadow);
`else
    assign frame_ok = 1'b1;
    assign cfg_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            shadow       <= '0;
            cnt          <= '0;
            RegSmuEn     <= 1'b0;
            RegInpSel    <= '0;
            RegMask      <= '0;
            RegCmp       <= '0;
            RegCmpSelect <= '0;
            RegFsmCmp    <= '0;
            SmuEn        <= 1'b0;
            load_done    <= 1'b0;
`ifdef SMU_CFG_PARITY_EN
            cfg_err      <= 1'b0;
`endif
        end else begin
            load_done <= 1'b0;
            if (state == COMMIT) begin
                if (frame_ok) begin
                    RegSmuEn     <= shadow[0];
                    RegInpSel    <= shadow[O_SEL +: BNS];
                    RegMask      <= shadow[O_MASK +: SEG];
                    RegCmp       <= shadow[O_CMP +: SEG];
                    RegCmpSelect <= shadow[O_CS +: 2];
                    RegFsmCmp    <= shadow[O_FSM +: FSM_W];
                    SmuEn        <= 1'b1;
                    load_done    <= 1'b1;
                    state        <= ACTIVE;
                end else begin
`ifdef SMU_CFG_PARITY_EN
                    cfg_err      <= 1'b1;
`endif
                    state        <= ERR;
                end
            end else if (acc && cfg_start) begin
                // A start beat always (re)starts a frame, even mid-frame
                shadow[0] <= cfg_bit;
                cnt       <= CW'(1);
                SmuEn     <= 1'b0;
`ifdef SMU_CFG_PARITY_EN
                cfg_err   <= 1'b0;
`endif
                state     <= SHIFT;
            end else if (acc && state == SHIFT) begin
                shadow[cnt] <= cfg_bit;
                cnt         <= cnt + CW'(1);
                if (cnt == CW'(FL - 1))
                    state <= COMMIT;
            end
        end
    end

endmodule

// File: doc/smu_cfg_loader.md
# smu_cfg_loader

Serial configuration loader sitting directly upstream of `smu_unit`. It deserialises a configuration bitstream into a shadow register and commits it atomically to the SMU comparison registers (`RegSmuEn`, `RegInpSel`, `RegMask`, `RegCmp`, `RegCmpSelect`, `RegFsmCmp`). It asserts `SmuEn` only once a complete, valid frame has been committed. The SMU therefore never observes a partially loaded configuration.

## Interface
Parameters:
- `N`, 2, maximum observation cycles; `RegFsmCmp` width is `$clog2(N)`.
- `K`, 4, observable signal bits.
- `SMU_SEGMENT_SIZE`, 64, mask and compare width.
- `SMU_NUM_SEGMENTS`, `(K+SMU_SEGMENT_SIZE-1)/SMU_SEGMENT_SIZE`, derived.
- `BITS_NUM_SEGMENTS`, 1 if `SMU_NUM_SEGMENTS==1`, else `$clog2(SMU_NUM_SEGMENTS)`, derived.
- `CFG_W`, `1+BITS_NUM_SEGMENTS+2*SMU_SEGMENT_SIZE+2+$clog2(N)`, derived payload bits.

Ports:
- `clk`  in  1  clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `cfg_valid`  in  1  beat valid.
- `cfg_bit`  in  1  serial payload bit.
- `cfg_start`  in  1  qualifies a beat as bit 0 of a new frame.
- `cfg_ready`  out  1  beat accepted when `cfg_valid & cfg_ready`.
- `RegSmuEn`  out  1  committed field.
- `RegInpSel`  out  `BITS_NUM_SEGMENTS`  committed field.
- `RegMask`, `RegCmp`  out  `SMU_SEGMENT_SIZE` each  committed fields.
- `RegCmpSelect`  out  2  committed field.
- `RegFsmCmp`  out  `$clog2(N)`  committed field.
- `SmuEn`  out  1  committed configuration valid.
- `load_done`  out  1  one-cycle pulse on commit.
- `cfg_err`  out  1  sticky frame error.

## Operation
- States: IDLE, SHIFT, COMMIT, ACTIVE, ERR.
- `cfg_ready` = 1 in every state except COMMIT.
- Frame layout is LSB-first, fields packed contiguously from bit 0: `RegSmuEn`, `RegInpSel`, `RegMask`, `RegCmp`, `RegCmpSelect`, `RegFsmCmp`. Each field is also LSB-first.
- IDLE, ACTIVE or ERR, accepted beat with `cfg_start=1`:
  - Bit 0 is stored and the bit counter set to 1.
  - State goes to SHIFT; `SmuEn` goes to 0; `cfg_err` is cleared.
- Accepted beats with `cfg_start=0` outside SHIFT are discarded.
- SHIFT, accepted beat with `cfg_start=0`: the bit is stored at the counter index and the counter increments.
- SHIFT, accepted beat with `cfg_start=1`: the frame aborts and restarts at bit 0 (same actions as a new start).
- When the final frame bit is accepted, state goes to COMMIT. The final bit is `CFG_W-1`, or the parity bit when parity is enabled.
- COMMIT, valid frame: shadow copied to all `Reg*` outputs, `SmuEn` set to 1, `load_done` pulsed, state goes to ACTIVE.
- COMMIT, invalid frame (parity enabled only): `cfg_err` set to 1, `Reg*` keep their old values, `SmuEn` stays 0, state goes to ERR.
- Bit counter width is `$clog2(CFG_W+2)`. The counter never wraps: it is reloaded on every start beat.

## Timing
- Reset (`rst=0`, asynchronous): state IDLE, all `Reg*` = 0, `SmuEn`=0, `load_done`=0, `cfg_err`=0, counter 0. `cfg_ready` = 1 once reset is released.
- Reset mid-frame discards the partial frame immediately.
- Start beat accepted at edge E: `SmuEn` = 0 from E onward.
- Final beat accepted at edge E: cycle E..E+1 is COMMIT with `cfg_ready`=0. At edge E+1, `Reg*` update, `SmuEn`=1 and `load_done`=1. `load_done` returns to 0 at E+2.
- A beat presented during COMMIT is not accepted; the source holds it.
- `cfg_valid` gaps are allowed anywhere in a frame; the frame result is unchanged.
- Minimum frame length is `CFG_W` accepted beats, plus 1 with parity; a back-to-back frame can start in the cycle after COMMIT.

## Configuration
- Macro: `SMU_CFG_PARITY_EN`.
- Defined: the frame carries one extra bit at index `CFG_W`, giving even parity over payload plus parity bit. A mismatch takes the ERR path; `cfg_err` stays 1 until the next start beat or reset.
- Undefined: the frame is exactly `CFG_W` bits, ERR is unreachable, and `cfg_err` is tied to 0.

## Test plan
All scenarios use N=2, K=4, SEG=64, so `CFG_W`=133.
- **Reset values:** assert `rst=0` for 3 cycles -> all outputs 0 and `cfg_ready`=1 after release.
- **Full frame:** load `RegSmuEn`=1, `InpSel`=0, `Mask`=0xF, `Cmp`=0x5, `CmpSelect`=2'b11, `FsmCmp`=1 with continuous valid -> 1 edge after the final beat, outputs equal these values, `SmuEn`=1, `load_done` high for exactly 1 cycle.
- **Gaps and mid-frame restart:** random `cfg_valid` gaps, then `cfg_start` re-asserted at bit 70, then a full new frame with `Cmp`=0xA -> only 0xA is committed, `SmuEn`=0 from the restart until commit, and the old `Reg*` hold meanwhile.
- **Reset mid-frame:** `rst=0` at bit 40 -> `SmuEn`=0, `Reg*`=0, and a following start beat is accepted.
- **Stray beats:** beats without `cfg_start` in ACTIVE -> ignored; `Reg*` and `SmuEn` unchanged.
- **Parity error (`SMU_CFG_PARITY_EN`):** 134-bit frame with a wrong parity bit -> `cfg_err`=1, `SmuEn`=0, `Reg*` keep their previous values; the next good frame clears `cfg_err` and commits.
